// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [15:0] CNT_MAX           = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == CNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating fetch/stall event counters; only built when FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_inc_i,
    input  logic        stall_inc_i,
    output logic [15:0] fetch_cnt_o,
    output logic [15:0] stall_cnt_o
);

    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign fetch_cnt_d = fetch_inc_i ? sat_inc(fetch_cnt_q) : fetch_cnt_q;
    assign stall_cnt_d = stall_inc_i ? sat_inc(stall_cnt_q) : stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/fetch_controller.sv
// IF stage: PC sequencing, IF/ID register, halt detection and redirect handling.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt/stall_cnt performance counters.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W    = 2,
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_pc_plus4,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       stall_cnt,
`endif
    output logic              halted
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_pc_plus4_q, if_pc_plus4_d;

    // NOTE: every output of this block gets a hold default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;

        if (redirect_valid) begin
            pc_d       = redirect_pc & 32'hFFFF_FFFC;
            if_valid_d = 1'b0;
            state_d    = RUN;
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (flush) begin
                        if_valid_d = 1'b0;
                    end else if (!stall) begin
                        // The halt word never reaches decode; pc stays on it.
                        if (imem_data == HALT_WORD) begin
                            if_valid_d = 1'b0;
                            state_d    = HALT;
                        end else begin
                            if_valid_d    = 1'b1;
                            if_instr_d    = imem_data;
                            if_pc_d       = pc_q;
                            if_pc_plus4_d = pc_q + 32'd4;
                            pc_d          = pc_q + 32'd4;
                        end
                    end
                end
                HALT:    ;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            if_pc_plus4_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
        end
    end

    assign imem_addr   = pc_q[ADDR_W+1:2];
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign halted      = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic fetch_inc;
    logic stall_inc;

    assign fetch_inc = (state_q == RUN) && !redirect_valid && !flush && !stall
                       && (imem_data != HALT_WORD);
    assign stall_inc = (state_q == RUN) && stall;

    fetch_perf_counters u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_inc_i (fetch_inc),
        .stall_inc_i (stall_inc),
        .fetch_cnt_o (fetch_cnt),
        .stall_cnt_o (stall_cnt)
    );
`endif

endmodule
